alu_nibble_seq: RTL and testbench
=================================

ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 req_valid  input  1  command present.
REQ-003 req_ready  output  1  block can accept a command.
REQ-004 req_opcode  input  3  operation: 000 add, 001 sub, 010 and, 011 or, 100 not A, 101-111 invalid.
REQ-005 req_a  input  8  operand A.
REQ-006 req_b  input  8  operand B.
REQ-007 rsp_valid  output  1  response present.
REQ-008 rsp_ready  input  1  consumer accepts the response.
REQ-009 rsp_result  output  8  8-bit result.
REQ-010 rsp_carry  output  1  add carry-out / sub borrow-out; 0 for all other opcodes.
REQ-011 rsp_zero  output  1  1 when rsp_result == 8'h00.
REQ-012 busy  output  1  1 in every state except IDLE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, LO, HI, RSP.
REQ-014 Transitions SHALL be: IDLE->LO on req_valid&&req_ready; LO->HI unconditionally; HI->RSP unconditionally; RSP->IDLE on rsp_ready; otherwise hold.
REQ-015 req_ready SHALL be 1 only in IDLE.
REQ-016 On accept, opcode, A and B SHALL be registered; input changes after accept SHALL have no effect.
REQ-017 LO SHALL compute bits [3:0] through the nibble slice with carry/borrow-in 0 and register the slice result and carry.
REQ-018 HI SHALL compute bits [7:4] with carry/borrow-in equal to the carry/borrow registered in LO, and register the final 8-bit result, carry and zero.
REQ-019 Add: {carry,result} = A + B, 9-bit.
REQ-020 Sub: result = (A - B) mod 256; carry = 1 iff A < B unsigned.
REQ-021 Logical ops and invalid opcodes: carry = 0; nibble carry-in ignored; invalid opcodes give result 8'h00, zero 1.
REQ-022 If accept occurs in cycle N, rsp_valid SHALL be 1 from cycle N+3 until the cycle in which rsp_ready is sampled 1, inclusive.
REQ-023 rsp_result, rsp_carry, rsp_zero SHALL be held stable while rsp_valid && !rsp_ready.
REQ-024 rsp_valid SHALL be 0 in IDLE, LO and HI.
REQ-025 Maximum throughput SHALL be one command per 4 cycles, with rsp_ready held 1.
REQ-026 req_valid in a non-IDLE state SHALL be ignored and not queued.

Reset
REQ-027 While rst_n == 0, the state SHALL be IDLE, and rsp_valid, rsp_result, rsp_carry, rsp_zero, busy and all internal registers SHALL be 0.
REQ-028 req_ready SHALL be 1 in the first cycle after reset is released.
REQ-029 Reset asserted in any state SHALL abort the in-flight command with no response issued.

Structure
REQ-030 Shared package alu_pkg SHALL hold the opcode constants and the FSM state typedef.
REQ-031 A single combinational sub-module alu_nibble_slice SHALL implement the 4-bit operation: inputs a[3:0], b[3:0], opcode, cin; outputs y[3:0], cout.
REQ-032 alu_nibble_seq SHALL instantiate alu_nibble_slice once and reuse it in LO and HI.

Verification
REQ-033 add A=8'hFF B=8'h01 -> result 8'h00, carry 1, zero 1, rsp_valid at N+3.
REQ-034 sub A=8'h10 B=8'h01 -> result 8'h0F, carry 0; sub A=8'h05 B=8'h06 -> 8'hFF, carry 1.
REQ-035 and A=8'hF0 B=8'h3C -> 8'h30, carry 0; not A=8'hA5 -> 8'h5A; opcode 111 -> 8'h00, zero 1.
REQ-036 Backpressure: hold rsp_ready 0 for 5 cycles after rsp_valid -> outputs stable and req_ready 0 throughout; rsp_ready 1 -> IDLE next cycle.
REQ-037 Change A/B after accept, and pulse req_valid while busy -> response reflects the captured operands only, and no extra response is issued.
REQ-038 Assert rst_n=0 while in HI -> rsp_valid never rises, all outputs 0; after release, add 8'h01+8'h02 -> 8'h03.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the nibble-serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit ALU slice; cout is carry-out for add, borrow-out for sub.
module alu_nibble_slice
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] opcode,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);

  logic [4:0] w_sum;
  logic [4:0] w_diff;

  // Bit 4 of the 5-bit difference goes high exactly when a < b + cin.
  assign w_sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign w_diff = {1'b0, a} - {1'b0, b} - {4'b0000, cin};

  always_comb begin
    y    = 4'h0;
    cout = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        y    = w_sum[3:0];
        cout = w_sum[4];
      end
      OP_SUB: begin
        y    = w_diff[3:0];
        cout = w_diff[4];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      default: y = 4'h0;
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// 8-bit ALU that processes one command as two nibble passes through a single
// shared slice, then holds the response until the consumer takes it.
module alu_nibble_seq
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_opcode,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       busy
);

  state_t     r_state;
  logic [2:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [3:0] r_lo;
  logic       r_c;
  logic [7:0] r_result;
  logic       r_carry;
  logic       r_zero;
  logic       r_valid;

  logic       w_hi_pass;
  logic [3:0] w_sa;
  logic [3:0] w_sb;
  logic       w_cin;
  logic [3:0] w_y;
  logic       w_cout;

  // The slice sees the low nibble with cin=0 everywhere except HI.
  assign w_hi_pass = (r_state == ST_HI);
  assign w_sa      = w_hi_pass ? r_a[7:4] : r_a[3:0];
  assign w_sb      = w_hi_pass ? r_b[7:4] : r_b[3:0];
  assign w_cin     = w_hi_pass ? r_c : 1'b0;

  alu_nibble_slice u_slice (
    .a      (w_sa),
    .b      (w_sb),
    .opcode (r_op),
    .cin    (w_cin),
    .y      (w_y),
    .cout   (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= 3'b000;
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_lo     <= 4'h0;
      r_c      <= 1'b0;
      r_result <= 8'h00;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= req_opcode;
            r_a     <= req_a;
            r_b     <= req_b;
            r_state <= ST_LO;
          end
        end
        ST_LO: begin
          r_lo    <= w_y;
          r_c     <= w_cout;
          r_state <= ST_HI;
        end
        ST_HI: begin
          r_result <= {w_y, r_lo};
          r_carry  <= w_cout;
          r_zero   <= ({w_y, r_lo} == 8'h00);
          r_valid  <= 1'b1;
          r_state  <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign rsp_valid  = r_valid;
  assign rsp_result = r_result;
  assign rsp_carry  = r_carry;
  assign rsp_zero   = r_zero;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Scoreboard bench for alu_nibble_seq: directed corner cases, backpressure,
// busy-time noise, mid-command reset and a short random run.
module tb_alu_nibble_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_opcode;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       busy;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic       zero;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_sent   = 0;
  int   n_rsp    = 0;

  always #5 clk = ~clk;

  alu_nibble_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) n_rsp++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e = '0;
    case (op)
      3'b000: {e.carry, e.result} = {1'b0, a} + {1'b0, b};
      3'b001: begin e.result = a - b; e.carry = (a < b); end
      3'b010: e.result = a & b;
      3'b011: e.result = a | b;
      3'b100: e.result = ~a;
      default: e.result = 8'h00;
    endcase
    e.zero = (e.result == 8'h00);
    return e;
  endfunction

  // Drive one command from a negedge; returns at the negedge of cycle N+3.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input bit noisy);
    int w;
    int cnt;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    check_val("req_ready_before_send", req_ready, 1);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    sb_q.push_back(model(op, a, b));
    n_sent++;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (noisy) begin
      req_a = 8'($urandom); req_b = 8'($urandom);
      req_opcode = 3'($urandom); req_valid = 1'b1;
    end
    check_val("rsp_valid_n1", rsp_valid, 0);
    check_val("busy_n1", busy, 1);
    check_val("req_ready_n1", req_ready, 0);
    cnt = 1;
    while (!rsp_valid && cnt < 10) begin @(negedge clk); cnt++; end
    req_valid = 1'b0;
    check_val("latency", cnt, 3);
  endtask

  // Hold rsp_ready low for 'hold' cycles, then complete the handshake.
  task automatic recv(input int hold);
    exp_t e;
    exp_t obs;
    check_val("sb_nonempty", (sb_q.size() > 0), 1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    obs = {rsp_result, rsp_carry, rsp_zero};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_valid", rsp_valid, 1);
      check_val("hold_stable", {rsp_result, rsp_carry, rsp_zero}, obs);
      check_val("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    check_val("result", rsp_result, e.result);
    check_val("carry", rsp_carry, e.carry);
    check_val("zero", rsp_zero, e.zero);
    $display("rsp result=%02h carry=%0b zero=%0b hold=%0d", rsp_result, rsp_carry, rsp_zero, hold);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("idle_valid", rsp_valid, 0);
    check_val("idle_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = 3'b000; req_a = 8'h00; req_b = 8'h00;
    repeat (2) @(negedge clk);
    check_val("rst_outputs", {rsp_valid, rsp_result, rsp_carry, rsp_zero, busy}, 0);
    rst_n = 1'b1;
    #1 check_val("rst_release_ready", req_ready, 1);
    @(negedge clk);

    send(OP_ADD, 8'hFF, 8'h01, 0); recv(0);
    send(OP_SUB, 8'h10, 8'h01, 0); recv(0);
    send(OP_SUB, 8'h05, 8'h06, 0); recv(1);
    send(OP_AND, 8'hF0, 8'h3C, 0); recv(0);
    send(OP_NOT, 8'hA5, 8'h00, 0); recv(0);
    send(3'b111, 8'h12, 8'h34, 0); recv(0);
    send(OP_OR,  8'h0F, 8'h30, 0); recv(5);

    // Operand changes and req_valid pulses while busy must be ignored.
    send(OP_ADD, 8'h37, 8'h19, 1); recv(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("no_extra_rsp", rsp_valid, 0);
    end

    // Reset in HI aborts the command; nothing comes out afterwards.
    req_valid = 1'b1; req_opcode = OP_ADD; req_a = 8'h80; req_b = 8'h80;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_val("in_hi_busy", busy, 1);
    rst_n = 1'b0;
    #1 check_val("abort_outputs", {rsp_valid, rsp_result, rsp_carry, rsp_zero, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_val("abort_release_ready", req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("abort_no_rsp", rsp_valid, 0);
    end
    send(OP_ADD, 8'h01, 8'h02, 0); recv(0);

    for (int i = 0; i < 8; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
      recv(int'($urandom_range(0, 2)));
    end

    check_val("rsp_count", n_rsp, n_sent);
    check_val("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
